// File: rtl/tama_cmd_pkg.sv
// Shared constants for the UART command decoder: action codes,
// decoder state encoding, ASCII constants and the letter map.
package tama_cmd_pkg;

   localparam logic [2:0] ACT_FEED      = 3'd0;
   localparam logic [2:0] ACT_PLAY      = 3'd1;
   localparam logic [2:0] ACT_CLEAN     = 3'd2;
   localparam logic [2:0] ACT_SLEEP     = 3'd3;
   localparam logic [2:0] ACT_HEAL      = 3'd4;
   localparam logic [2:0] ACT_STATUS    = 3'd5;
   localparam logic [2:0] ACT_PET_RESET = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ARG,
      ST_DISCARD,
      ST_ISSUE
   } state_t;

   localparam logic [7:0] CH_CR   = 8'h0D;
   localparam logic [7:0] CH_LF   = 8'h0A;
   localparam logic [7:0] CH_ZERO = 8'h30;

   typedef struct packed {
      logic       ok;
      logic [2:0] code;
   } letter_t;

   // '?' has no case partner, so it is matched before bit 5 is masked.
   function automatic letter_t decode_letter(input logic [7:0] b);
      letter_t    r;
      logic [7:0] up;
      up     = b & 8'hDF;
      r.ok   = 1'b1;
      r.code = ACT_FEED;
      if (b == 8'h3F) begin
         r.code = ACT_STATUS;
      end else begin
         case (up)
            8'h46:   r.code = ACT_FEED;
            8'h50:   r.code = ACT_PLAY;
            8'h43:   r.code = ACT_CLEAN;
            8'h53:   r.code = ACT_SLEEP;
            8'h4D:   r.code = ACT_HEAL;
            8'h52:   r.code = ACT_PET_RESET;
            default: r.ok   = 1'b0;
         endcase
      end
      return r;
   endfunction

   function automatic logic is_term(input logic [7:0] b);
      return (b == CH_CR) || (b == CH_LF);
   endfunction

   function automatic logic is_digit(input logic [7:0] b);
      return (b > CH_ZERO) && (b <= 8'h39);
   endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// Turns the receiver's held byte into a one-cycle strobe on each
// 0x00 -> nonzero transition. Ports: clk, rst_n, rx_byte in; byte_stb, rx_data out.
module uart_byte_strobe (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_byte,
   output logic       byte_stb,
   output logic [7:0] rx_data
);

   logic [7:0] prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= 8'h00;
      else        prev_q <= rx_byte;
   end

   assign byte_stb = (rx_byte != 8'h00) && (prev_q == 8'h00);
   assign rx_data  = rx_byte;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses "<letter>[1-9]<CR|LF>" lines into held ready/valid action requests.
// Ports: clk, rst_n, rx_byte, is_sleeping, action_ready in;
//   action_valid, action_code, action_amount, cmd_error, err_count, busy out.
// Option: UART_CMD_SLEEP_LOCK_EN limits sleeping pets to S and ? commands.
module uart_cmd_decoder
   import tama_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 27000000,
   parameter int ERR_CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           rx_byte,
   input  logic                 is_sleeping,
   output logic                 action_valid,
   input  logic                 action_ready,
   output logic [2:0]           action_code,
   output logic [3:0]           action_amount,
   output logic                 cmd_error,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 busy
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic          stb;
   logic [7:0]    bval;
   state_t        state_q, state_d;
   logic [2:0]    code_q, code_d;
   logic [3:0]    amt_q, amt_d;
   logic [TW-1:0] tcnt_q;
   logic          err_ev;
   logic          err_q;
   logic [ERR_CNT_W-1:0] errs_q;
   logic          active;
   logic          tout;
   logic          term;
   logic          allowed;
   letter_t       dec;

   uart_byte_strobe u_stb (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_byte  (rx_byte),
      .byte_stb (stb),
      .rx_data  (bval)
   );

   assign dec  = decode_letter(bval);
   assign term = is_term(bval);

`ifdef UART_CMD_SLEEP_LOCK_EN
   assign allowed = !is_sleeping
                  || (dec.code == ACT_SLEEP)
                  || (dec.code == ACT_STATUS);
`else
   logic sleep_unused;
   assign sleep_unused = is_sleeping;
   assign allowed      = 1'b1;
`endif

   assign active = (state_q == ST_CMD)
                || (state_q == ST_ARG)
                || (state_q == ST_DISCARD);
   // A byte on the expiry cycle wins, so tout is masked by stb.
   assign tout = active && !stb
              && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      amt_d   = amt_q;
      err_ev  = 1'b0;
      case (state_q)
         ST_IDLE: if (stb) begin
            if (dec.ok && allowed) begin
               code_d  = dec.code;
               amt_d   = 4'd1;
               state_d = ST_CMD;
            end else if (!term) begin
               state_d = ST_DISCARD;
            end
         end
         ST_CMD: begin
            if (stb) begin
               if (is_digit(bval)) begin
                  // ASCII '1'..'9' carry the value in the low nibble.
                  amt_d   = bval[3:0];
                  state_d = ST_ARG;
               end else if (term) begin
                  state_d = ST_ISSUE;
               end else begin
                  state_d = ST_DISCARD;
               end
            end else if (tout) begin
               err_ev  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_ARG: begin
            if (stb) begin
               state_d = term ? ST_ISSUE : ST_DISCARD;
            end else if (tout) begin
               err_ev  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_DISCARD: begin
            if (stb) begin
               if (term) begin
                  err_ev  = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (tout) begin
               err_ev  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: if (action_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         code_q  <= 3'd0;
         amt_q   <= 4'd0;
         err_q   <= 1'b0;
         errs_q  <= '0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         amt_q   <= amt_d;
         err_q   <= err_ev;
         if (err_ev && !(&errs_q)) errs_q <= errs_q + 1'b1;
         if (stb || !active) tcnt_q <= '0;
         else                tcnt_q <= tcnt_q + 1'b1;
      end
   end

   assign action_valid  = (state_q == ST_ISSUE);
   assign action_code   = code_q;
   assign action_amount = amt_q;
   assign cmd_error     = err_q;
   assign err_count     = errs_q;
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed scenarios plus
// randomized command lines checked against a line-level reference model.
module tb_uart_cmd_decoder;

   localparam int TO = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       is_sleeping = 1'b0;
   logic       action_ready = 1'b0;
   logic       action_valid;
   logic [2:0] action_code;
   logic [3:0] action_amount;
   logic       cmd_error;
   logic [7:0] err_count;
   logic       busy;

   int total = 0;
   int bad   = 0;

   logic [6:0] xq[$];
   int  err_pulses   = 0;
   int  valid_cycles = 0;
   bit  rdy_rand     = 0;

   always #5 clk = ~clk;

   uart_cmd_decoder #(
      .TIMEOUT_CYCLES (TO),
      .ERR_CNT_W      (8)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_byte       (rx_byte),
      .is_sleeping   (is_sleeping),
      .action_valid  (action_valid),
      .action_ready  (action_ready),
      .action_code   (action_code),
      .action_amount (action_amount),
      .cmd_error     (cmd_error),
      .err_count     (err_count),
      .busy          (busy)
   );

   // Observe transfers and error pulses mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (action_valid) valid_cycles++;
         if (action_valid && action_ready)
            xq.push_back({action_code, action_amount});
         if (cmd_error) err_pulses++;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_rand) action_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_byte = b;
      tick(3);
      rx_byte = 8'h00;
      tick(3);
   endtask

   task automatic apply_reset();
      rdy_rand     = 0;
      rst_n        = 1'b0;
      rx_byte      = 8'h00;
      action_ready = 1'b0;
      is_sleeping  = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      xq.delete();
      err_pulses   = 0;
      valid_cycles = 0;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (busy && n < 400) begin
         tick(1);
         n++;
      end
      if (busy) begin
         total++;
         bad++;
         $display("FAIL %s: busy=%0b after %0d cycles, required 0",
                  nm, busy, n);
      end
      tick(2);
   endtask

   function automatic void ref_letter(input logic [7:0] c,
                                      output bit ok,
                                      output logic [2:0] code);
      ok = 1;
      code = 3'd0;
      case (c)
         "F", "f": code = 3'd0;
         "P", "p": code = 3'd1;
         "C", "c": code = 3'd2;
         "S", "s": code = 3'd3;
         "M", "m": code = 3'd4;
         "?":      code = 3'd5;
         "R", "r": code = 3'd6;
         default:  ok = 0;
      endcase
   endfunction

   // kind: 0 nothing, 1 action, 2 rejected line
   function automatic void model_line(input logic [7:0] body[$],
                                      input bit slp,
                                      output int kind,
                                      output logic [6:0] exp);
      bit         ok;
      bit         alw;
      logic [2:0] code;
      logic [3:0] amt;
      kind = 0;
      exp  = 7'd0;
      if (body.size() == 0) return;
      ref_letter(body[0], ok, code);
`ifdef UART_CMD_SLEEP_LOCK_EN
      alw = !slp || code == 3'd3 || code == 3'd5;
`else
      alw = 1;
      if (slp) alw = 1;
`endif
      amt = 4'd1;
      if (body.size() == 2) amt = 4'(body[1] - 8'h30);
      if (ok && alw && (body.size() == 1 ||
          (body.size() == 2 && body[1] >= "1" && body[1] <= "9"))) begin
         kind = 1;
         exp  = {code, amt};
      end else begin
         kind = 2;
      end
   endfunction

   task automatic test_reset();
      apply_reset();
      total++;
      if ({action_valid, action_code, action_amount,
           cmd_error, err_count, busy} !== 17'd0) begin
         bad++;
         $display("FAIL reset: v=%0b c=%0d a=%0d e=%0b n=%0d b=%0b, required all 0",
                  action_valid, action_code, action_amount,
                  cmd_error, err_count, busy);
      end
   endtask

   task automatic test_single();
      apply_reset();
      action_ready = 1'b1;
      send_byte("F");
      send_byte("3");
      rx_byte = 8'h0D;
      tick(1);
      total++;
      if (action_valid !== 1'b1) begin
         bad++;
         $display("FAIL latency: valid=%0b, required 1", action_valid);
      end
      tick(2);
      rx_byte = 8'h00;
      tick(4);
      total++;
      if (valid_cycles !== 1) begin
         bad++;
         $display("FAIL valid_width: got %0d cycles, required 1",
                  valid_cycles);
      end
      total++;
      if (xq.size() !== 1 || xq[0] !== {3'd0, 4'd3}) begin
         bad++;
         $display("FAIL f3_xfer: n=%0d first=%0h, required 1 and 03",
                  xq.size(), xq.size() ? xq[0] : 7'h7F);
      end
      total++;
      if (err_pulses !== 0) begin
         bad++;
         $display("FAIL f3_err: got %0d pulses, required 0", err_pulses);
      end
   endtask

   task automatic test_hold();
      int badc;
      apply_reset();
      send_byte("p");
      send_byte(8'h0D);
      send_byte(8'h0A);
      badc = 0;
      for (int i = 0; i < 50; i++) begin
         if (action_valid !== 1'b1 || action_code !== 3'd1
             || action_amount !== 4'd1) badc++;
         tick(1);
      end
      total++;
      if (badc != 0) begin
         bad++;
         $display("FAIL hold: %0d bad cycles, required 0", badc);
      end
      action_ready = 1'b1;
      total++;
      if (action_valid !== 1'b1) begin
         bad++;
         $display("FAIL hold_xfer: valid=%0b, required 1", action_valid);
      end
      tick(1);
      action_ready = 1'b0;
      total++;
      if (action_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL hold_drop: valid=%0b busy=%0b, required 0 0",
                  action_valid, busy);
      end
      tick(3);
      total++;
      if (xq.size() !== 1 || err_pulses !== 0) begin
         bad++;
         $display("FAIL hold_lf: xfers=%0d errs=%0d, required 1 0",
                  xq.size(), err_pulses);
      end
   endtask

   task automatic test_errors();
      apply_reset();
      action_ready = 1'b1;
      send_byte("F");
      send_byte("0");
      send_byte(8'h0D);
      send_byte("X");
      send_byte(8'h0D);
      send_byte(8'h0D);
      send_byte(8'h0A);
      tick(3);
      total++;
      if (err_pulses !== 2 || err_count !== 8'd2 || xq.size() !== 0) begin
         bad++;
         $display("FAIL errors: pulses=%0d cnt=%0d xfers=%0d, required 2 2 0",
                  err_pulses, err_count, xq.size());
      end
   endtask

   task automatic test_timeout();
      int k;
      apply_reset();
      action_ready = 1'b1;
      rx_byte = "C";
      k = 0;
      while (!cmd_error && k < 200) begin
         tick(1);
         k++;
         if (k == 3) rx_byte = 8'h00;
      end
      total++;
      if (k < TO - 5 || k > TO + 5) begin
         bad++;
         $display("FAIL timeout_at: error after %0d cycles, required about %0d",
                  k, TO);
      end
      total++;
      if (busy !== 1'b0 || err_count !== 8'd1) begin
         bad++;
         $display("FAIL timeout_state: busy=%0b cnt=%0d, required 0 1",
                  busy, err_count);
      end
      tick(2);
      send_byte("S");
      send_byte(8'h0D);
      tick(3);
      total++;
      if (xq.size() !== 1 || xq[0] !== {3'd3, 4'd1}) begin
         bad++;
         $display("FAIL after_timeout: n=%0d first=%0h, required 1 and 31",
                  xq.size(), xq.size() ? xq[0] : 7'h7F);
      end
   endtask

   task automatic test_midreset();
      apply_reset();
      action_ready = 1'b1;
      send_byte("X");
      send_byte(8'h0D);
      action_ready = 1'b0;
      send_byte("F");
      send_byte(8'h0D);
      total++;
      if (action_valid !== 1'b1 || err_count !== 8'd1) begin
         bad++;
         $display("FAIL pre_reset: valid=%0b cnt=%0d, required 1 1",
                  action_valid, err_count);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (action_valid !== 1'b0 || busy !== 1'b0
          || err_count !== 8'd0) begin
         bad++;
         $display("FAIL mid_reset: valid=%0b busy=%0b cnt=%0d, required 0 0 0",
                  action_valid, busy, err_count);
      end
      tick(2);
      rst_n = 1'b1;
      action_ready = 1'b1;
      tick(4);
      total++;
      if (action_valid !== 1'b0) begin
         bad++;
         $display("FAIL dropped: valid=%0b, required 0", action_valid);
      end
   endtask

   task automatic test_sleep();
      apply_reset();
      action_ready = 1'b1;
      is_sleeping  = 1'b1;
      send_byte("F");
      send_byte(8'h0D);
      tick(3);
`ifdef UART_CMD_SLEEP_LOCK_EN
      total++;
      if (err_pulses !== 1 || xq.size() !== 0) begin
         bad++;
         $display("FAIL sleep_f: errs=%0d xfers=%0d, required 1 0",
                  err_pulses, xq.size());
      end
`else
      total++;
      if (err_pulses !== 0 || xq.size() !== 1 || xq[0] !== 7'h01) begin
         bad++;
         $display("FAIL sleep_f: errs=%0d xfers=%0d, required 0 1 (01)",
                  err_pulses, xq.size());
      end
`endif
      xq.delete();
      send_byte("?");
      send_byte(8'h0D);
      tick(3);
      total++;
      if (xq.size() !== 1 || xq[0] !== {3'd5, 4'd1}) begin
         bad++;
         $display("FAIL sleep_q: n=%0d first=%0h, required 1 and 51",
                  xq.size(), xq.size() ? xq[0] : 7'h7F);
      end
   endtask

   task automatic test_random();
      logic [7:0] pool [0:21];
      logic [7:0] body[$];
      logic [6:0] exp;
      int kind, nx, ne, len, errs_exp;
      pool = '{"F", "P", "C", "S", "M", "?", "R", "f", "p", "c", "s",
               "m", "r", "0", "1", "5", "9", "X", "z", "!", " ", "7"};
      apply_reset();
      rdy_rand = 1;
      errs_exp = 0;
      for (int ln = 0; ln < 40; ln++) begin
         body.delete();
         len = $urandom_range(0, 3);
         for (int j = 0; j < len; j++) begin
            if (j == 0 && $urandom_range(0, 3) != 0)
               body.push_back(pool[$urandom_range(0, 12)]);
            else
               body.push_back(pool[$urandom_range(0, 21)]);
         end
         is_sleeping = 1'($urandom_range(0, 1));
         model_line(body, is_sleeping, kind, exp);
         nx = xq.size();
         ne = err_pulses;
         foreach (body[j]) send_byte(body[j]);
         case ($urandom_range(0, 2))
            0: send_byte(8'h0D);
            1: send_byte(8'h0A);
            default: begin
               send_byte(8'h0D);
               send_byte(8'h0A);
            end
         endcase
         wait_idle("rand_idle");
         if (kind == 2) errs_exp++;
         total++;
         if (xq.size() - nx !== (kind == 1 ? 1 : 0)
             || err_pulses - ne !== (kind == 2 ? 1 : 0)) begin
            bad++;
            $display("FAIL rand_line%0d: xfers=%0d errs=%0d, required kind %0d",
                     ln, xq.size() - nx, err_pulses - ne, kind);
         end else if (kind == 1) begin
            total++;
            if (xq[nx] !== exp) begin
               bad++;
               $display("FAIL rand_data%0d: got %0h, required %0h",
                        ln, xq[nx], exp);
            end
         end
      end
      rdy_rand = 0;
      total++;
      if (err_count !== 8'(errs_exp)) begin
         bad++;
         $display("FAIL rand_errcnt: got %0d, required %0d",
                  err_count, errs_exp);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_hold();
      test_errors();
      test_timeout();
      test_midreset();
      test_sleep();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
